// File: rtl/halt_pkg.sv
// Shared types for the simulation-exit path: sequencer states and halt cause encodings.
package halt_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EBREAK  = 2'd1,
    CAUSE_ILLEGAL = 2'd2,
    CAUSE_HANG    = 2'd3
  } cause_t;

endpackage

// File: rtl/halt_watchdog.sv
// Saturating event counter with clear/enable; terminal pulses while enabled on the count of LIMIT-1.
module halt_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W = $clog2(LIMIT) + 1;
  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  // Clear wins over terminal so a retiring instruction on the last cycle averts the hang.
  assign terminal = enable && !clear && (count == TC_VAL);

endmodule

// File: rtl/halt_sequencer.sv
// Freezes fetch on ebreak/illegal/hang, drains outstanding bus traffic, then latches exit state.
module halt_sequencer
  import halt_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned HANG_LIMIT    = 4096,
  parameter int unsigned CNT_W         = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               is_break_out,
  input  logic               is_unknown_instruction,
  input  logic [31:0]        event_pc,
  input  logic [31:0]        a0_value,
  input  logic               commit_valid,
  input  logic               ifu_busy,
  input  logic               lsu_busy,
  output logic               fetch_stall,
  output logic               halted,
  output logic [CAUSE_W-1:0] halt_cause,
  output logic               drain_timeout,
  output logic               good_trap,
  output logic [31:0]        halt_pc,
  output logic [31:0]        halt_code,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  state_t state;
  cause_t run_cause;
  logic   in_run;
  logic   not_drain;
  logic   hang_tc;
  logic   drain_tc;

  assign in_run    = (state == ST_RUN);
  assign not_drain = (state != ST_DRAIN);

  halt_watchdog #(.LIMIT(HANG_LIMIT)) u_hang_wd (
    .clock    (clock),
    .reset    (reset),
    .clear    (commit_valid),
    .enable   (in_run),
    .terminal (hang_tc)
  );

  halt_watchdog #(.LIMIT(DRAIN_TIMEOUT)) u_drain_wd (
    .clock    (clock),
    .reset    (reset),
    .clear    (not_drain),
    .enable   (1'b1),
    .terminal (drain_tc)
  );

  always_comb begin
    run_cause = CAUSE_NONE;
    if (is_unknown_instruction) run_cause = CAUSE_ILLEGAL;
    else if (is_break_out)      run_cause = CAUSE_EBREAK;
    else if (hang_tc)           run_cause = CAUSE_HANG;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_RUN;
      fetch_stall   <= 1'b0;
      halted        <= 1'b0;
      halt_cause    <= '0;
      drain_timeout <= 1'b0;
      halt_pc       <= '0;
      halt_code     <= '0;
      cycle_cnt     <= '0;
      instret_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // The event cycle's own count update is part of the frozen snapshot.
          cycle_cnt   <= cycle_cnt + CNT_W'(1);
          instret_cnt <= instret_cnt + CNT_W'(commit_valid);
          if (run_cause != CAUSE_NONE) begin
            state       <= ST_DRAIN;
            fetch_stall <= 1'b1;
            halt_cause  <= run_cause;
            halt_pc     <= (run_cause == CAUSE_HANG) ? 32'd0 : event_pc;
            halt_code   <= a0_value;
          end
        end
        ST_DRAIN: begin
          if (!ifu_busy && !lsu_busy) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (drain_tc) begin
            state         <= ST_HALTED;
            halted        <= 1'b1;
            drain_timeout <= 1'b1;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign good_trap = halted && (halt_cause == CAUSE_EBREAK) && (halt_code == 32'd0);

endmodule

// File: doc/halt_sequencer.md
Name: halt_sequencer

Overview:
- Controls the simulation exit path of the single-cycle core.
- Takes the raw ebreak and illegal-instruction flags from decode/execute and freezes fetch.
- Drains outstanding IFU/LSU bus transactions, then latches the exit cause, PC, exit code (a0) and performance counters.
- Asserts a sticky halted indication that the testbench/DPI layer uses to end simulation and report GOOD/BAD trap.

Parameters:
- DRAIN_TIMEOUT, 64, max cycles to wait in DRAIN before forcing halt.
- HANG_LIMIT, 4096, consecutive cycles without commit_valid before a hang halt is raised.
- CNT_W, 64, width of cycle and instret counters.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- is_break_out  in  1  ebreak executed this cycle.
- is_unknown_instruction  in  1  illegal/unknown opcode decoded this cycle.
- event_pc  in  32  PC of the instruction raising the event.
- a0_value  in  32  current GPR x10, used as the exit code.
- commit_valid  in  1  one instruction retired this cycle.
- ifu_busy  in  1  instruction fetch transaction outstanding.
- lsu_busy  in  1  load/store transaction outstanding.
- fetch_stall  out  1  blocks new fetch and commit; high in DRAIN and HALTED.
- halted  out  1  sticky; set on entry to HALTED.
- halt_cause  out  2  0 NONE, 1 EBREAK, 2 ILLEGAL, 3 HANG.
- drain_timeout  out  1  HALTED was reached via DRAIN_TIMEOUT.
- good_trap  out  1  halted && cause==EBREAK && halt_code==0.
- halt_pc  out  32  latched event_pc (0 for HANG).
- halt_code  out  32  latched a0_value.
- cycle_cnt  out  CNT_W  cycles since reset; frozen at event capture.
- instret_cnt  out  CNT_W  commits since reset; frozen at event capture.

Behaviour:
- Synchronous, active-high reset; all state is registered.
- Reset values: state RUN, all outputs 0, counters 0.
- Reset asserted in any state returns the block to RUN next edge, including mid-DRAIN and HALTED.
- Reset has priority over all events.
- States:
  - RUN: cycle_cnt += 1 each cycle. instret_cnt += commit_valid. Hang counter clears on commit_valid, otherwise increments.
  - RUN event priority: is_unknown_instruction > is_break_out > hang (hang counter == HANG_LIMIT-1 with no commit).
  - RUN on event: latch cause, event_pc (HANG: 0), a0_value. The counter update of the event cycle is included. Go to DRAIN.
  - DRAIN: fetch_stall=1. Further events are ignored and latched values are not overwritten. Drain counter starts at 0.
  - DRAIN exit, normal: !ifu_busy && !lsu_busy → HALTED.
  - DRAIN exit, timeout: drain counter == DRAIN_TIMEOUT-1 with busy still high → HALTED with drain_timeout=1.
  - HALTED: fetch_stall=1, halted=1. Terminal until reset. All latched outputs hold.
- Latency:
  - Event sampled at edge N: fetch_stall and halt_cause are valid after edge N.
  - Busy already low: halted after edge N+1.
  - Minimum event-to-halted latency is 2 edges.
- Counters:
  - Counters wrap modulo 2^CNT_W; there is no saturation.
  - The hang counter is log2(HANG_LIMIT)+1 bits and saturates.
- halt_cause/halt_pc/halt_code are valid whenever state != RUN; they are 0 in RUN.
- good_trap is combinational from registered state.

Decomposition:
- Shared package halt_pkg:
  - state enum RUN/DRAIN/HALTED.
  - cause encodings CAUSE_NONE/EBREAK/ILLEGAL/HANG.
  - width constant for halt_cause.
- One natural sub-module: halt_watchdog.
  - Parameterised saturating counter with clear/enable and a terminal-count pulse.
  - Instantiated twice: hang detection (clear=commit_valid, enable=RUN) and drain timeout (clear=state!=DRAIN).

Test Plan:
- Reset, 10 cycles of commit_valid=1, ebreak with a0=0, pc=0x80000010, busy low.
  - halted=1 two edges after the event; cause=1, good_trap=1, halt_pc=0x80000010, instret_cnt=11.
- Ebreak with a0=5.
  - good_trap=0, halt_code=5.
- Simultaneous is_break_out and is_unknown_instruction at pc=0x80000020.
  - cause=2; a later ebreak in DRAIN does not change cause or PC.
- Event while lsu_busy=1 for 7 cycles.
  - fetch_stall holds high and halted rises the edge after lsu_busy drops; drain_timeout=0.
  - With lsu_busy stuck: halted at DRAIN entry+64 edges, drain_timeout=1.
- No commit_valid for 4096 cycles.
  - cause=3, halt_pc=0.
  - One commit at cycle 4095 restarts the count; no halt occurs.
- Reset asserted in DRAIN and again in HALTED.
  - Next edge: RUN, all outputs 0, counters restart from 0.
